// File: rtl/step_ramp.sv
// Trapezoidal-acceleration STEP/DIR pulse generator for one wheel; ramps half-period START_HALF -> target -> START_HALF.
// Latency: state entry one clk25 after valid is sampled; first STEP edge DIR_SETUP cycles later.
// Backpressure: level-held valid; ready only in DONE; dropping valid mid-move aborts to IDLE next edge.
`timescale 1ns/1ps
module step_ramp #(
    parameter int unsigned START_HALF = 12500,
    parameter int unsigned ACCEL_DEC  = 8,
    parameter int unsigned DIR_SETUP  = 50
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        valid,
    input  logic        dir_in,
    input  logic [31:0] step_num,
    input  logic [31:0] half_top,
    output logic        ready,
    output logic        busy,
    output logic        step_out,
    output logic        dir_out,
    output logic [31:0] steps_done
);

    localparam logic [31:0] START_W = 32'(START_HALF);
    localparam logic [31:0] ACC_W   = 32'(ACCEL_DEC);
    localparam logic [31:0] SETUP_W = 32'(DIR_SETUP);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

    state_t      state;
    logic [31:0] num_q, tgt, cur, acc, cnt;
    logic [31:0] tgt_in, sd_inc, rem, cur_up, cur_dn;

    // Clamped neighbours of cur; compares avoid wrap in 32-bit unsigned math.
    always_comb begin
        tgt_in = (half_top == 32'd0) ? 32'd1 : half_top;
        sd_inc = steps_done + 32'd1;
        rem    = num_q - sd_inc;
        cur_up = START_W;
        if (cur < START_W && (START_W - cur) > ACC_W)
            cur_up = cur + ACC_W;
        cur_dn = tgt;
        if (cur > tgt && (cur - tgt) > ACC_W)
            cur_dn = cur - ACC_W;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            steps_done <= 32'd0;
            num_q      <= 32'd0;
            tgt        <= 32'd0;
            cur        <= 32'd0;
            acc        <= 32'd0;
            cnt        <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        num_q      <= step_num;
                        tgt        <= tgt_in;
                        cur        <= (START_W > tgt_in) ? START_W : tgt_in;
                        acc        <= 32'd0;
                        cnt        <= 32'd0;
                        dir_out    <= dir_in;
                        steps_done <= 32'd0;
                        if (step_num == 32'd0) begin
                            state <= S_DONE;
                            ready <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_SETUP, S_HIGH, S_LOW: begin
                    if (!valid) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        step_out <= 1'b0;
                        cnt      <= 32'd0;
                    end else if (state == S_SETUP) begin
                        if (cnt + 32'd1 >= SETUP_W) begin
                            state    <= S_HIGH;
                            step_out <= 1'b1;
                            cnt      <= 32'd0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end else if (cnt != cur - 32'd1) begin
                        cnt <= cnt + 32'd1;
                    end else if (state == S_HIGH) begin
                        state    <= S_LOW;
                        step_out <= 1'b0;
                        cnt      <= 32'd0;
                    end else begin
                        steps_done <= sd_inc;
                        cnt        <= 32'd0;
                        if (rem == 32'd0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            state    <= S_HIGH;
                            step_out <= 1'b1;
                            // Decelerate once the remaining steps match the steps spent accelerating.
                            if (rem <= acc) begin
                                cur <= cur_up;
                                acc <= (acc == 32'd0) ? 32'd0 : acc - 32'd1;
                            end else if (cur > tgt) begin
                                cur <= cur_dn;
                                acc <= acc + 32'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!valid) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ready    <= 1'b0;
                    busy     <= 1'b0;
                    step_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_ramp.sv
// Bench for step_ramp: expected STEP high/low widths queued at command time, popped as pulses are measured.
`timescale 1ns/1ps
module tb_step_ramp;

    localparam int START_HALF = 20;
    localparam int ACCEL_DEC  = 5;
    localparam int DIR_SETUP  = 4;
    localparam int BOUND      = 1000;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        dir_in = 1'b0;
    logic [31:0] step_num = 32'd0;
    logic [31:0] half_top = 32'd0;
    logic        ready, busy, step_out, dir_out;
    logic [31:0] steps_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    step_ramp #(.START_HALF(START_HALF), .ACCEL_DEC(ACCEL_DEC), .DIR_SETUP(DIR_SETUP)) dut (
        .clk25(clk25), .rst(rst), .valid(valid), .dir_in(dir_in),
        .step_num(step_num), .half_top(half_top), .ready(ready), .busy(busy),
        .step_out(step_out), .dir_out(dir_out), .steps_done(steps_done)
    );

    always #20 clk25 = ~clk25;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic drive(input logic d, input int num, input int half);
        dir_in   = d;
        step_num = 32'(num);
        half_top = 32'(half);
        valid    = 1'b1;
    endtask

    task automatic push_profile(input int w[$]);
        foreach (w[i]) begin
            exp_q.push_back(w[i]);
            exp_q.push_back(w[i]);
        end
    endtask

    // Measure npulses STEP pulses: high width, then low width up to the next rise or ready.
    task automatic measure(input int npulses, input int setup_exp);
        int t, w, e;
        for (int i = 0; i < npulses; i++) begin
            t = 0;
            while (step_out !== 1'b1 && t < BOUND) begin tick(); t++; end
            n_checks++;
            if (t >= BOUND) begin
                n_fail++;
                $display("FAIL pulse_timeout: pulse %0d never rose within %0d cycles", i, BOUND);
                return;
            end
            if (i == 0 && setup_exp >= 0) begin
                n_checks++;
                if (t !== setup_exp) begin
                    n_fail++;
                    $display("FAIL setup_delay: got %0d cycles expected %0d", t, setup_exp);
                end
            end
            for (int ph = 0; ph < 2; ph++) begin
                w = 0;
                if (ph == 0)
                    while (step_out === 1'b1 && w < BOUND) begin tick(); w++; end
                else
                    while (step_out === 1'b0 && ready !== 1'b1 && busy === 1'b1 && w < BOUND) begin tick(); w++; end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (w !== e) begin
                    n_fail++;
                    $display("FAIL width_%s pulse %0d: got %0d expected %0d", (ph == 0) ? "high" : "low", i, w, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        #5;
        n_checks++;
        if ({ready, busy, step_out, dir_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {ready, busy, step_out, dir_out});
        end
        n_checks++;
        if (steps_done !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_steps_done: got %0d expected 0", steps_done);
        end
        @(negedge clk25);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp_and_hold();
        int fails_here;
        push_profile('{20, 15, 10, 10, 15, 20});
        drive(1'b1, 6, 10);
        measure(6, DIR_SETUP + 1);
        n_checks++;
        if (dir_out !== 1'b1) begin n_fail++; $display("FAIL ramp_dir_out: got %b expected 1", dir_out); end
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done_flags: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
        end
        n_checks++;
        if (steps_done !== 32'd6) begin n_fail++; $display("FAIL ramp_steps_done: got %0d expected 6", steps_done); end
        fails_here = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_out !== 1'b0 || ready !== 1'b1) fails_here++;
        end
        n_checks++;
        if (fails_here != 0) begin
            n_fail++;
            $display("FAIL hold_done: got %0d bad cycles expected 0", fails_here);
        end
        valid = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b expected 0", ready); end
    endtask

    task automatic test_triangle();
        push_profile('{20, 15, 20});
        drive(1'b0, 3, 10);
        measure(3, DIR_SETUP + 1);
        n_checks++;
        if (dir_out !== 1'b0 || ready !== 1'b1 || steps_done !== 32'd3) begin
            n_fail++;
            $display("FAIL triangle_end: got dir=%b ready=%b steps=%0d expected 0 1 3", dir_out, ready, steps_done);
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_zero_steps();
        int pulses;
        drive(1'b1, 0, 10);
        tick();
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got ready=%b busy=%b expected 1 0", ready, busy);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL zero_pulses: got %0d expected 0", pulses); end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_constant_rate();
        push_profile('{25, 25, 25, 25});
        drive(1'b1, 4, 25);
        measure(4, DIR_SETUP + 1);
        n_checks++;
        if (steps_done !== 32'd4 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL const_end: got steps=%0d ready=%b expected 4 1", steps_done, ready);
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_abort_restart();
        push_profile('{20, 15});
        drive(1'b1, 6, 10);
        measure(2, DIR_SETUP + 1);
        n_checks++;
        if (step_out !== 1'b1) begin n_fail++; $display("FAIL abort_precond: got step_out=%b expected 1", step_out); end
        valid = 1'b0;
        tick();
        n_checks++;
        if (step_out !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags: got step=%b busy=%b ready=%b expected 0 0 0", step_out, busy, ready);
        end
        n_checks++;
        if (steps_done !== 32'd2) begin n_fail++; $display("FAIL abort_steps_done: got %0d expected 2", steps_done); end
        tick();
        push_profile('{20, 15, 10, 10, 15, 20});
        drive(1'b1, 6, 10);
        measure(6, DIR_SETUP + 1);
        valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_low();
        int w;
        push_profile('{20});
        drive(1'b1, 6, 10);
        measure(1, -1);
        w = 0;
        while (step_out === 1'b1 && w < BOUND) begin tick(); w++; end
        tick(); tick(); tick();
        n_checks++;
        if (steps_done !== 32'd1 || busy !== 1'b1 || step_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_precond: got steps=%0d busy=%b step=%b expected 1 1 0", steps_done, busy, step_out);
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if ({ready, busy, step_out, dir_out} !== 4'b0000 || steps_done !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: got flags=%b steps=%0d expected 0000 0",
                     {ready, busy, step_out, dir_out}, steps_done);
        end
        valid = 1'b0;
        @(negedge clk25);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp_and_hold();
        test_triangle();
        test_zero_steps();
        test_constant_rate();
        test_abort_restart();
        test_reset_mid_low();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_ramp.md
Name: step_ramp

Overview:
- Trapezoidal-acceleration step pulse generator for one mecanum wheel.
- Sits between the motion-command logic (IR/key decode) and the STEP/DIR driver pins. One instance per wheel (fl/fr/bl/br).
- Accepts the same valid/ready command as the constant-rate stepper: direction, step count, target half-period.
- Ramps step rate up from a safe start rate and back down, so the 16 kHz cruise rate does not stall the motors.

Parameters:
- START_HALF, 12500, start/stop half-period in clk25 cycles (1 kHz step rate).
- ACCEL_DEC, 8, half-period change in cycles applied per completed step.
- DIR_SETUP, 50, cycles DIR is held stable before the first STEP edge (2 us).

Ports:
- clk25  in  1  system clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  command request. Level-held by the master. Low = stop.
- dir_in  in  1  direction, latched at command accept.
- step_num  in  32  number of full steps, latched at accept.
- half_top  in  32  target (cruise) half-period in cycles, latched at accept.
- ready  out  1  high while in DONE (command complete).
- busy  out  1  high in SETUP/HIGH/LOW.
- step_out  out  1  STEP pin drive.
- dir_out  out  1  DIR pin drive. Changes only at command accept.
- steps_done  out  32  full steps issued for the current command.

Behaviour:
- Reset (async): state=IDLE, ready=0, busy=0, step_out=0, dir_out=0, steps_done=0, internal counters=0.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - When valid=1, latch the command. Internal target tgt = max(half_top,1); cur = max(START_HALF,tgt); acc=0. Set dir_out=dir_in, steps_done=0.
  - If step_num=0, go to DONE. Else go to SETUP. Entry is one cycle after valid is sampled high.
- SETUP: hold DIR_SETUP cycles with step_out=0, then go to HIGH.
- HIGH: step_out=1 for exactly cur cycles, then go to LOW.
- LOW: step_out=0 for exactly cur cycles. On the last LOW cycle:
  - steps_done += 1. Let rem = step_num - new steps_done.
  - If rem=0, go to DONE.
  - Else if rem <= acc: cur = min(cur+ACCEL_DEC, START_HALF), acc -= 1 (floor 0).
  - Else if cur > tgt: cur = max(cur-ACCEL_DEC, tgt), acc += 1.
  - Else cur is unchanged.
  - Then go to HIGH.
- Profile is symmetric: the decel step count equals the accel step count. A short move gives a triangle profile.
- If tgt >= START_HALF, the rate is constant at tgt with no ramp.
- DONE: ready=1, busy=0, step_out=0. Stay in DONE until valid=0, then go to IDLE. A still-high valid never restarts the same command.
- Abort: valid=0 in SETUP/HIGH/LOW forces IDLE on the next edge. step_out=0 immediately on that edge, ready is not asserted, and steps_done holds its count.
- Commands presented while busy are ignored. Latched values never change mid-move.
- All arithmetic is 32-bit unsigned. The clamps prevent underflow and overflow of cur.
- rst mid-move returns all outputs to reset values immediately. It is asynchronous, so no STEP pulse is truncated to a glitch longer than the reset.

Test Plan:
- START_HALF=20, ACCEL_DEC=5, DIR_SETUP=4. Command step_num=6, half_top=10, dir_in=1 -> dir_out=1 one cycle after accept. First step_out rise after 4 SETUP cycles. High/low widths are 20,15,10,10,15,20 cycles. steps_done=6, ready=1. step_out stays 0 afterwards.
- Same parameters, step_num=3 -> widths 20,15,20 (triangle). ready=1 after the final LOW.
- step_num=0 -> DONE one cycle after IDLE accept. ready=1, zero step_out pulses.
- half_top=25 (greater than START_HALF), step_num=4 -> all widths 25, no ramp.
- Drop valid during step 3 HIGH of the 6-step run -> step_out=0 next cycle, state IDLE, ready stays 0, steps_done=2. A new valid restarts from cur=20.
- Hold valid high through DONE for 10 cycles -> no new pulses, ready stays 1. Drop valid -> ready=0 next cycle. Assert rst mid-LOW -> all outputs 0 asynchronously.
